i2s_slave_tx: RTL and testbench
===============================

I2S_SLAVE_TX -- requirements
Module: i2s_slave_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 16: bits per channel sample.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: stereo frames buffered; power of 2.
REQ-003 SHALL have port wb_clk_i, input, 1: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port wb_rst_i, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port en_i, input, 1: transmitter enable.
REQ-006 SHALL have port frame_l_i, input, DATA_W: left sample of the pushed frame.
REQ-007 SHALL have port frame_r_i, input, DATA_W: right sample of the pushed frame.
REQ-008 SHALL have port frame_valid_i, input, 1: push request.
REQ-009 SHALL have port frame_ready_o, output, 1: FIFO not full.
REQ-010 SHALL have port sck_i, input, 1: I2S bit clock from the external master.
REQ-011 SHALL have port ws_i, input, 1: I2S word select from the master; 0 selects left, 1 selects right.
REQ-012 SHALL have port sd_o, output, 1: I2S serial data to the master's data input.
REQ-013 SHALL have port underrun_o, output, 1: sticky underrun flag.
REQ-014 SHALL have port level_o, output, $clog2(FIFO_DEPTH)+1: FIFO occupancy.

Function
REQ-015 SHALL synchronize sck_i and ws_i through 2-flop synchronizers, then detect sck edges from the synchronized value and its 1-cycle delayed copy; the sck period SHALL be at least 8 wb_clk_i periods.
REQ-016 SHALL accept a push when frame_valid_i && frame_ready_o; frame_ready_o = !full, combinational from the registered count.
REQ-017 SHALL sample ws only on synchronized sck falling edges ("fe"), keeping the previous sampled value ws_prev.
REQ-018 SHALL implement FSM IDLE, SYNC and RUN.
 - IDLE: entered when en_i=0 from any state; sd_o=0; shift register cleared; no pops.
 - IDLE->SYNC: when en_i=1.
 - SYNC->RUN: at the first fe where ws_prev=1 and ws=0 (left start); right starts seen in SYNC are ignored.
REQ-019 In RUN, at each fe: sd_o <= sreg[DATA_W-1]; sreg <= sreg<<1, with zero fill.
 - Slots longer than DATA_W SHALL output zero padding.
 - Slots shorter than DATA_W SHALL truncate the LSBs.
REQ-020 In RUN, at a fe where ws changes, sd_o SHALL still take the current sreg MSB, and sreg SHALL be loaded with the new channel word instead of shifting; this gives the standard one-SCK MSB delay.
REQ-021 At a left start (1->0) with the FIFO non-empty, the block SHALL pop one frame in that wb_clk_i cycle, load sreg with its left word, and hold its right word in rhold.
REQ-022 At a right start (0->1), the block SHALL load sreg from rhold.
REQ-023 At a left start with the FIFO empty, the block SHALL load sreg and rhold with zero and set underrun_o.
 - underrun_o SHALL clear only on reset or when en_i=0.
REQ-024 A push and a pop in the same cycle SHALL leave level_o unchanged.
 - A push while full SHALL be impossible, because ready=0.
 - A push in the same cycle as a pop from an empty FIFO SHALL store the frame and still signal underrun.
REQ-025 Pushes SHALL be accepted in every state; disabling SHALL NOT flush the FIFO.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; level_o SHALL range from 0 to FIFO_DEPTH.

Reset
REQ-027 wb_rst_i=1 SHALL immediately force:
 - state=IDLE, sd_o=0, underrun_o=0, level_o=0, frame_ready_o=1;
 - sreg, rhold, pointers and synchronizers to 0.
REQ-028 Reset asserted mid-frame SHALL discard the FIFO contents and the partial word; after release the block SHALL wait for a fresh left start in SYNC.

Verification
REQ-029 Basic: DATA_W=16, 16 SCK per slot; push (L=0xA5C3, R=0x0F0F); enable; run one frame -> sd_o captured on sck rising edges, starting one SCK after each ws edge, is 0xA5C3 then 0x0F0F; level_o goes 1->0 at the left start.
REQ-030 Underrun: enable with the FIFO empty -> all sd_o bits are 0 for the frame and underrun_o=1; en_i=0 clears it.
REQ-031 Full: push 5 frames back-to-back with no SCK -> 4 accepted, level_o=4, frame_ready_o=0 on the 5th; after one left start level_o=3 and ready=1.
REQ-032 Slot padding: 24 SCK per slot, L=0xFFFF -> 16 ones followed by 8 zeros on sd_o.
REQ-033 Mid-stream enable: raise en_i while ws=1 (right slot) -> sd_o stays 0 until the next 1->0 ws transition, then the first frame's left MSB appears one SCK later.
REQ-034 Reset mid-frame: assert wb_rst_i after 5 bits of the left word -> sd_o=0 and level_o=0 within the same cycle; after release, the next pushed frame is transmitted intact.

Source files
------------

// File: rtl/i2s_slave_tx.sv
// I2S slave transmitter: a stereo-frame FIFO on the system clock that feeds a
// shift register clocked by the externally supplied SCK/WS, which are synchronized and edge-detected.
module i2s_slave_tx #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          en_i,
  input  logic [DATA_W-1:0]             frame_l_i,
  input  logic [DATA_W-1:0]             frame_r_i,
  input  logic                          frame_valid_i,
  output logic                          frame_ready_o,
  input  logic                          sck_i,
  input  logic                          ws_i,
  output logic                          sd_o,
  output logic                          underrun_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  state_t              state;
  logic                sck_s1, sck_s2, sck_d;
  logic                ws_s1, ws_s2, ws_prev;
  logic [DATA_W-1:0]   sreg, rhold;
  logic [DATA_W-1:0]   mem_l [FIFO_DEPTH];
  logic [DATA_W-1:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       count;

  logic fe, left_start, right_start, empty, full, push, pop;

  always_comb begin
    fe            = sck_d & ~sck_s2;
    left_start    = fe & ws_prev & ~ws_s2;
    right_start   = fe & ~ws_prev & ws_s2;
    empty         = (count == '0);
    full          = (count == DEPTH_L);
    frame_ready_o = ~full;
    push          = frame_valid_i & ~full;
    pop           = en_i & (state != IDLE) & left_start & ~empty;
    level_o       = count;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_d   <= 1'b0;
      ws_s1   <= 1'b0;
      ws_s2   <= 1'b0;
      ws_prev <= 1'b0;
    end else begin
      sck_s1 <= sck_i;
      sck_s2 <= sck_s1;
      sck_d  <= sck_s2;
      ws_s1  <= ws_i;
      ws_s2  <= ws_s1;
      if (fe)
        ws_prev <= ws_s2;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem_l[wr_ptr] <= frame_l_i;
      mem_r[wr_ptr] <= frame_r_i;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // The SYNC->RUN left start is a real left start: it pops and loads the word
  // so the first frame's MSB goes out one SCK later, exactly as in RUN.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      sd_o       <= 1'b0;
      sreg       <= '0;
      rhold      <= '0;
      underrun_o <= 1'b0;
    end else if (!en_i) begin
      state      <= IDLE;
      sd_o       <= 1'b0;
      sreg       <= '0;
      rhold      <= '0;
      underrun_o <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= SYNC;
        SYNC, RUN: begin
          if (state == SYNC && left_start)
            state <= RUN;
          if (fe && state == RUN)
            sd_o <= sreg[DATA_W-1];
          if (left_start) begin
            if (!empty) begin
              sreg  <= mem_l[rd_ptr];
              rhold <= mem_r[rd_ptr];
            end else begin
              sreg       <= '0;
              rhold      <= '0;
              underrun_o <= 1'b1;
            end
          end else if (state == RUN && right_start) begin
            sreg <= rhold;
          end else if (state == RUN && fe) begin
            sreg <= {sreg[DATA_W-2:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_slave_tx.sv
// Directed bench for i2s_slave_tx: plays the I2S master on SCK/WS and
// records sd_o on every SCK rising edge, then checks the extracted words.
module tb_i2s_slave_tx;
  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst, en, valid, sck, ws;
  logic [DATA_W-1:0] fl, fr;
  logic              ready, sd, underrun;
  logic [2:0]        level;

  int   checks = 0;
  int   errors = 0;
  logic bits [$];
  int   l0, r0, e0;

  always #5 clk = ~clk;

  i2s_slave_tx #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .en_i(en),
    .frame_l_i(fl), .frame_r_i(fr), .frame_valid_i(valid), .frame_ready_o(ready),
    .sck_i(sck), .ws_i(ws), .sd_o(sd), .underrun_o(underrun), .level_o(level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // master changes WS on the SCK falling edge; the slave's bit is taken at the rising edge
  task automatic sck_cycle(input logic w);
    sck = 1'b0;
    ws  = w;
    #80;
    bits.push_back(sd);
    sck = 1'b1;
    #80;
  endtask

  task automatic slot(input int n, input logic w);
    repeat (n) sck_cycle(w);
  endtask

  function automatic logic [31:0] word(input int start, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], bits[start+i]};
    return v;
  endfunction

  task automatic push(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    fl = l; fr = r; valid = 1'b1;
    #10;
    valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #20;
    rst = 1'b0;
    #10;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; valid = 1'b0; sck = 1'b1; ws = 1'b1; fl = '0; fr = '0;
    #10;
    check("rst_sd", {31'd0, sd}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    #10;
    rst = 1'b0;
    #10;

    // basic frame
    push(16'hA5C3, 16'h0F0F);
    check("basic_level_push", {29'd0, level}, 32'd1);
    en = 1'b1;
    slot(16, 1'b1);
    check("basic_level_sync", {29'd0, level}, 32'd1);
    l0 = bits.size();
    sck_cycle(1'b0);
    check("basic_level_pop", {29'd0, level}, 32'd0);
    slot(15, 1'b0);
    r0 = bits.size();
    slot(16, 1'b1);
    slot(1, 1'b0);
    check("basic_pre_bit", {31'd0, bits[l0]}, 32'd0);
    check("basic_left", word(l0 + 1, 16), 32'hA5C3);
    check("basic_right", word(r0 + 1, 16), 32'h0F0F);

    // underrun
    en = 1'b0;
    #20;
    check("underrun_clr0", {31'd0, underrun}, 32'd0);
    en = 1'b1;
    slot(16, 1'b1);
    l0 = bits.size();
    slot(16, 1'b0);
    slot(16, 1'b1);
    slot(1, 1'b0);
    check("underrun_bits", word(l0 + 1, 32), 32'd0);
    check("underrun_set", {31'd0, underrun}, 32'd1);
    en = 1'b0;
    #20;
    check("underrun_clr", {31'd0, underrun}, 32'd0);

    // full FIFO
    push(16'h1111, 16'h2222);
    push(16'h3333, 16'h4444);
    push(16'h5555, 16'h6666);
    push(16'h7777, 16'h8888);
    check("full_level", {29'd0, level}, 32'd4);
    check("full_ready", {31'd0, ready}, 32'd0);
    push(16'h9999, 16'hAAAA);
    check("full_level_5th", {29'd0, level}, 32'd4);
    en = 1'b1;
    slot(16, 1'b1);
    l0 = bits.size();
    sck_cycle(1'b0);
    check("full_level_pop", {29'd0, level}, 32'd3);
    check("full_ready_pop", {31'd0, ready}, 32'd1);
    slot(15, 1'b0);
    slot(1, 1'b1);
    check("full_first_left", word(l0 + 1, 16), 32'h1111);
    en = 1'b0;

    // 24-SCK slots pad with zeros
    do_reset();
    push(16'hFFFF, 16'h0000);
    en = 1'b1;
    slot(24, 1'b1);
    l0 = bits.size();
    slot(24, 1'b0);
    slot(24, 1'b1);
    slot(1, 1'b0);
    check("pad_ones", word(l0 + 1, 16), 32'hFFFF);
    check("pad_zeros", word(l0 + 17, 8), 32'd0);

    // enable in the middle of a right slot
    do_reset();
    en = 1'b0;
    push(16'hC001, 16'h8003);
    slot(8, 1'b1);
    en = 1'b1;
    e0 = bits.size();
    slot(8, 1'b1);
    l0 = bits.size();
    slot(16, 1'b0);
    r0 = bits.size();
    slot(16, 1'b1);
    slot(1, 1'b0);
    check("midena_quiet", word(e0, 8), 32'd0);
    check("midena_pre_bit", {31'd0, bits[l0]}, 32'd0);
    check("midena_left", word(l0 + 1, 16), 32'hC001);
    check("midena_right", word(r0 + 1, 16), 32'h8003);

    // reset after five bits of a left word
    push(16'hFC00, 16'h1111);
    slot(15, 1'b0);
    slot(16, 1'b1);
    l0 = bits.size();
    slot(6, 1'b0);
    check("rstmid_bits", word(l0 + 1, 5), 32'h1F);
    check("rstmid_sd_before", {31'd0, sd}, 32'd1);
    push(16'hAAAA, 16'hBBBB);
    check("rstmid_level_before", {29'd0, level}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid_sd", {31'd0, sd}, 32'd0);
    check("rstmid_level", {29'd0, level}, 32'd0);
    check("rstmid_ready", {31'd0, ready}, 32'd1);
    #19;
    rst = 1'b0;
    #10;
    push(16'h6B1D, 16'h9E37);
    slot(10, 1'b0);
    slot(16, 1'b1);
    l0 = bits.size();
    slot(16, 1'b0);
    r0 = bits.size();
    slot(16, 1'b1);
    slot(1, 1'b0);
    check("rstmid_left", word(l0 + 1, 16), 32'h6B1D);
    check("rstmid_right", word(r0 + 1, 16), 32'h9E37);
    check("rstmid_level_after", {29'd0, level}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
